// File: rtl/vx_ibuffer_arb.sv
// Round-robin arbiter sharing one instruction-buffer slave port among per-warp buffers.
// Multi-instruction groups stay atomic: the winner holds the grant until its group drains.
module vx_ibuffer_arb #(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned DATAW    = 256,
  parameter int unsigned REQ_SELW = $clog2(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  input  logic [NUM_REQS*4-1:0]     grp_cnt_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic [REQ_SELW-1:0]       sel_out,
  input  logic                      ready_out,
  output logic                      locked
);

  localparam int unsigned CNTW = 4;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  state_e              r_state, w_state_nxt;
  logic [REQ_SELW-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [REQ_SELW-1:0] r_locked_idx, w_locked_idx_nxt;
  logic [CNTW-1:0]     r_remaining, w_remaining_nxt;

  logic                r_valid_out;
  logic [DATAW-1:0]    r_data_out;
  logic [REQ_SELW-1:0] r_sel_out;

  logic [DATAW-1:0]    w_data [NUM_REQS];
  logic [CNTW-1:0]     w_cnt  [NUM_REQS];
  logic                w_can_load;
  logic                w_grant_ok;
  logic [REQ_SELW-1:0] w_grant_idx;
  logic [NUM_REQS-1:0] w_ready;
  logic                w_fire;

  function automatic logic [REQ_SELW-1:0] wrap_inc(input logic [REQ_SELW-1:0] x);
    if (32'(x) == NUM_REQS - 1) return '0;
    return x + REQ_SELW'(1);
  endfunction

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_unpack
    assign w_data[gi] = data_in[gi*DATAW +: DATAW];
    assign w_cnt[gi]  = grp_cnt_in[gi*CNTW +: CNTW];
  end

  // Grant is held low in reset so nothing is offered to the buffers.
  assign w_can_load = reset && (!r_valid_out || ready_out);

  // Grant select: locked requester, or first valid one at/after rr_ptr.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    w_grant_ok  = 1'b0;
    w_grant_idx = r_rr_ptr;
    if (r_state == ST_LOCKED) begin
      w_grant_ok  = 1'b1;
      w_grant_idx = r_locked_idx;
    end else begin
      for (int unsigned k = 0; k < NUM_REQS; k++) begin
        idx = 32'(r_rr_ptr) + k;
        if (idx >= NUM_REQS) idx = idx - NUM_REQS;
        if (!w_grant_ok && valid_in[REQ_SELW'(idx)]) begin
          w_grant_ok  = 1'b1;
          w_grant_idx = REQ_SELW'(idx);
        end
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_grant_ok) w_ready[w_grant_idx] = w_can_load;
  end

  assign w_fire   = |(w_ready & valid_in);
  assign ready_in = w_ready;

  // Lock FSM next-state: group start, follow-on countdown, pointer advance.
  always_comb begin
    w_state_nxt      = r_state;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_locked_idx_nxt = r_locked_idx;
    w_remaining_nxt  = r_remaining;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_fire) begin
          if (w_cnt[w_grant_idx] >= CNTW'(2)) begin
            w_state_nxt      = ST_LOCKED;
            w_locked_idx_nxt = w_grant_idx;
            w_remaining_nxt  = w_cnt[w_grant_idx] - CNTW'(1);
          end else begin
            w_rr_ptr_nxt = wrap_inc(w_grant_idx);
          end
        end
      end
      ST_LOCKED: begin
        if (w_fire) begin
          w_remaining_nxt = r_remaining - CNTW'(1);
          if (r_remaining == CNTW'(1)) begin
            w_state_nxt  = ST_UNLOCKED;
            w_rr_ptr_nxt = wrap_inc(r_locked_idx);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_UNLOCKED;
      r_rr_ptr     <= '0;
      r_locked_idx <= '0;
      r_remaining  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_locked_idx <= w_locked_idx_nxt;
      r_remaining  <= w_remaining_nxt;
    end
  end

  // Output stage: loads on fire, drains when downstream accepts, holds on stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_sel_out   <= '0;
    end else if (w_can_load) begin
      r_valid_out <= w_fire;
      if (w_fire) begin
        r_data_out <= w_data[w_grant_idx];
        r_sel_out  <= w_grant_idx;
      end
    end
  end

  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;
  assign sel_out   = r_sel_out;
  assign locked    = (r_state == ST_LOCKED);

endmodule

// File: doc/vx_ibuffer_arb.md
Name: VX_ibuffer_arb

Overview:
- Issue-side scheduler that shares one downstream instruction-buffer slave port among NUM_REQS per-warp instruction buffers.
- Picks one valid requester per cycle by round-robin and forwards its decoded instruction through a registered output stage.
- Keeps multi-instruction groups atomic: once the first member of a group (m_instr_cnt >= 2) issues, the arbiter stays locked on that requester until the whole group has issued.
- Sits between the per-warp ibuffers and the scoreboard/dispatch stage.

Parameters:
- NUM_REQS, 4, number of requesting warp buffers (>= 2).
- DATAW, 256, width of one packed instruction payload in bits.
- REQ_SELW, $clog2(NUM_REQS), width of the requester index.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- valid_in  input  NUM_REQS  per-requester valid.
- data_in  input  NUM_REQS*DATAW  payloads; requester i occupies bits [i*DATAW +: DATAW].
- grp_cnt_in  input  NUM_REQS*4  per-requester m_instr_cnt field, 4 bits each.
- ready_in  output  NUM_REQS  per-requester ready.
- valid_out  output  1  registered output valid.
- data_out  output  DATAW  registered payload.
- sel_out  output  REQ_SELW  index of the requester that supplied data_out.
- ready_out  input  1  downstream ready.
- locked  output  1  high while a group is partially issued.

Behaviour:
- Reset: reset low asynchronously clears all state.
  - valid_out=0, data_out=0, sel_out=0, locked=0.
  - rr_ptr=0, remaining=0.
  - Reset asserted mid-group drops the lock; the rest of the group is not tracked.
- Handshakes: a transfer occurs on a rising edge where valid && ready. Input fire_i = valid_in[i] && ready_in[i].
- Output stage: can_load = !valid_out || ready_out.
  - Full throughput: one instruction per cycle with ready_out held high.
  - Latency: exactly 1 cycle from input fire to valid_out.
  - On fire: data_out, sel_out and valid_out=1 load on the same edge.
  - If ready_out is high and nothing fires, valid_out clears.
  - While valid_out && !ready_out, data_out and sel_out hold stable.
- Grant, UNLOCKED:
  - Candidate set is all i with valid_in[i].
  - grant is the first candidate searching from rr_ptr upward, with modulo NUM_REQS wrap-around.
  - ready_in = onehot(grant) & {NUM_REQS{can_load}}. At most one bit is ever high.
  - ready_in is combinational from valid_in, the lock state and ready_out. No ready-to-valid dependency exists on inputs.
- Grant, LOCKED:
  - Only locked_idx is eligible. ready_in[locked_idx] = can_load; all other bits are 0, even if locked_idx is not valid (bubbles are allowed).
- State machine (locked bit):
  - UNLOCKED -> LOCKED on a fire from requester g with grp_cnt_in[g] >= 2.
    - Sets locked_idx=g and remaining=grp_cnt_in[g]-1.
    - rr_ptr is unchanged.
  - UNLOCKED, fire with grp_cnt_in[g] in {0,1}: single instruction. rr_ptr=(g+1) mod NUM_REQS.
  - LOCKED, fire:
    - remaining decrements.
    - If remaining was 1, go to UNLOCKED and set rr_ptr=(locked_idx+1) mod NUM_REQS.
    - grp_cnt_in is ignored for follow-on members.
  - LOCKED, no fire: hold.
- Width rules:
  - remaining is 4 bits.
  - grp_cnt value 15 gives 14 follow-ons.
  - rr_ptr increments wrap at NUM_REQS, including non-power-of-two values.
- Boundaries:
  - No valid inputs: no grant, ready_in=0.
  - Downstream stalled (valid_out && !ready_out): ready_in=0. Neither the lock state nor rr_ptr changes.
  - A single-cycle group-start and downstream drain on the same edge is legal; both take effect.

Test Plan:
1. Reset → outputs zero. Assert reset low for 3 cycles with all valid_in=1 → valid_out=0, ready_in=0000, locked=0. Release reset → first grant is requester 0 and valid_out rises one cycle later with sel_out=0.
2. Round-robin with ready_out=1 → NUM_REQS=4, all valid, grp_cnt=1 → sel_out sequence 0,1,2,3,0,1 on consecutive cycles, one instruction per cycle.
3. Group lock → requester 1 issues with grp_cnt=3 while requesters 0, 2 and 3 stay valid. Expected: sel_out=1,1,1, then 2. locked is high for exactly 2 cycles after the first fire.
4. Group bubble → during the lock, drop valid_in[1] for 2 cycles. Expected: no output for those cycles and requester 2 is not granted. The group finishes, then the arbiter resumes at requester 2.
5. Backpressure → hold ready_out=0 for 5 cycles with valid_out=1. Expected: data_out and sel_out stable, ready_in=0000, remaining unchanged. Raise ready_out → the stream continues with no loss or duplication; the scoreboard compares the full payloads.
6. Reset mid-group → assert reset after 1 of 4 group members. Expected: locked=0 and valid_out=0 immediately (asynchronous). After release, arbitration restarts at requester 0.
